// File: rtl/speed_gate_ctrl.sv
// speed_gate_ctrl: counts synchronised encoder rising edges over back-to-back
// gate windows of GATE_CYCLES clocks and publishes each count with a strobe.
module speed_gate_ctrl #(
   parameter int GATE_CYCLES = 25000000,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             enc_in,
   output logic [CNT_W-1:0] speed,
   output logic             speed_valid,
   output logic             overflow,
   output logic             busy
);

   localparam int TW = $clog2(GATE_CYCLES);
   localparam logic [TW-1:0] LAST = TW'(GATE_CYCLES - 1);

   typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;

   state_t           state, state_nxt;
   logic             s1, s2, s3;
   logic             rise;
   logic [TW-1:0]    timer;
   logic [CNT_W-1:0] cnt;
   logic             sat;
   logic             win_end;
   logic [CNT_W:0]   inc;

   // Saturating increment: MSB of the result flags an increment lost at full scale.
   function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] val,
                                              input logic inc_en);
      logic [CNT_W:0] res;
      if (inc_en && (val == {CNT_W{1'b1}}))
         res = {1'b1, val};
      else
         res = {1'b0, val + CNT_W'(inc_en)};
      return res;
   endfunction

   // Two-flop synchroniser plus edge register; rise is a single-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= enc_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign inc  = sat_inc(cnt, rise);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and window control: the last window cycle wins over an abort.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      win_end   = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = GATE;
         end
         GATE: begin
            busy = 1'b1;
            if (timer == LAST) begin
               win_end = 1'b1;
               if (!en) state_nxt = IDLE;
            end else if (!en) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Window timer, pulse counter and published result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer       <= '0;
         cnt         <= '0;
         sat         <= 1'b0;
         speed       <= '0;
         overflow    <= 1'b0;
         speed_valid <= 1'b0;
      end else begin
         speed_valid <= 1'b0;
         if (win_end) begin
            // Publish including a rise landing on the last cycle; restart cleanly.
            speed       <= inc[CNT_W-1:0];
            overflow    <= sat | inc[CNT_W];
            speed_valid <= 1'b1;
            timer       <= '0;
            cnt         <= '0;
            sat         <= 1'b0;
         end else if (busy && en) begin
            timer <= timer + TW'(1);
            cnt   <= inc[CNT_W-1:0];
            sat   <= sat | inc[CNT_W];
         end else begin
            // Idle or aborted window: discard partial count.
            timer <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_speed_gate_ctrl.sv
// Scoreboard bench for speed_gate_ctrl: a 16-bit and a 4-bit counter instance
// share all stimulus; expected window reports are queued by the stimulus and
// checked by an independent monitor when speed_valid appears.
module tb_speed_gate_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        enc_in = 1'b0;
   logic [15:0] speed16;
   logic        valid16, ovf16, busy16;
   logic [3:0]  speed4;
   logic        valid4, ovf4, busy4;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int sum16 = 0;

   typedef struct {
      int s16;
      int o16;
      int s4;
      int o4;
      int at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   speed_gate_ctrl #(.GATE_CYCLES(100), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .enc_in(enc_in),
      .speed(speed16), .speed_valid(valid16), .overflow(ovf16), .busy(busy16)
   );

   speed_gate_ctrl #(.GATE_CYCLES(100), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .enc_in(enc_in),
      .speed(speed4), .speed_valid(valid4), .overflow(ovf4), .busy(busy4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every strobe from either instance must match the next queued report.
   always @(negedge clk) begin
      if (!rst && (valid16 || valid4)) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got valid16=%0d valid4=%0d, expected none (cycle %0d)",
                     valid16, valid4, cyc);
         end else begin
            mon_e = sb.pop_front();
            cmp("valid16", int'(valid16), 1);
            cmp("valid4", int'(valid4), 1);
            cmp("valid_cycle", cyc, mon_e.at);
            cmp("speed16", int'(speed16), mon_e.s16);
            cmp("ovf16", int'(ovf16), mon_e.o16);
            cmp("speed4", int'(speed4), mon_e.s4);
            cmp("ovf4", int'(ovf4), mon_e.o4);
            sum16 = sum16 + int'(speed16);
         end
      end
   end

   initial begin
      int c0;
      int s0;

      // Reset: asserted between edges, outputs must clear at once.
      #2 rst = 1'b1;
      #1;
      cmp("rst_speed16", int'(speed16), 0);
      cmp("rst_valid16", int'(valid16), 0);
      cmp("rst_ovf16", int'(ovf16), 0);
      cmp("rst_busy16", int'(busy16), 0);
      cmp("rst_speed4", int'(speed4), 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();

      // Test 1: single window, 10 pulses 4 high / 4 low, en dropped at the strobe.
      c0 = cyc;
      en = 1'b1;
      sb.push_back('{10, 0, 10, 0, c0 + 101});
      for (int i = 0; i <= 102; i++) begin
         if (i > 0) tick();
         enc_in = (i < 80) && ((i % 8) < 4);
         if (i == 1)   cmp("t1_busy_rise", int'(busy16), 1);
         if (i == 101) en = 1'b0;
         if (i == 102) begin
            cmp("t1_busy_drop", int'(busy16), 0);
            cmp("t1_valid_one_cycle", int'(valid16), 0);
            cmp("t1_speed_hold", int'(speed16), 10);
         end
      end
      tick();

      // Test 2: continuous windows, pulse every 5 cycles with a rise on timer 99.
      c0 = cyc;
      s0 = sum16;
      en = 1'b1;
      for (int w = 1; w <= 5; w++) sb.push_back('{20, 0, 15, 1, c0 + 100 * w + 1});
      for (int i = 0; i <= 502; i++) begin
         if (i > 0) tick();
         enc_in = (i >= 3) && (i <= 498) && (((i - 3) % 5) == 0);
         if (i == 250) cmp("t2_busy_held", int'(busy16), 1);
         if (i == 501) en = 1'b0;
         if (i == 502) cmp("t2_busy_drop", int'(busy16), 0);
      end
      cmp("t2_sum_windows", sum16 - s0, 100);
      tick();

      // Test 3: saturation on the 4-bit instance, then a clean window.
      c0 = cyc;
      en = 1'b1;
      sb.push_back('{20, 0, 15, 1, c0 + 101});
      sb.push_back('{3, 0, 3, 0, c0 + 201});
      for (int i = 0; i <= 202; i++) begin
         if (i > 0) tick();
         enc_in = ((i < 40) && ((i % 2) == 0)) || ((i >= 110) && (i < 116) && ((i % 2) == 0));
         if (i == 201) en = 1'b0;
      end
      tick();

      // Test 4: report 7, abort at timer 50, then a fresh window after re-enable.
      c0 = cyc;
      en = 1'b1;
      sb.push_back('{7, 0, 7, 0, c0 + 101});
      sb.push_back('{1, 0, 1, 0, c0 + 361});
      for (int i = 0; i <= 362; i++) begin
         if (i > 0) tick();
         enc_in = ((i < 14) && ((i % 2) == 0)) || (i == 120) || (i == 270);
         if (i == 151) en = 1'b0;
         if (i == 152) begin
            cmp("t4_busy_abort", int'(busy16), 0);
            cmp("t4_speed_kept", int'(speed16), 7);
         end
         if (i == 259) cmp("t4_speed_kept_idle", int'(speed16), 7);
         if (i == 260) en = 1'b1;
         if (i == 261) cmp("t4_busy_reenable", int'(busy16), 1);
         if (i == 361) en = 1'b0;
      end
      tick();

      // Test 5: input held high across windows; its rise lands on timer 0 of window 2.
      c0 = cyc;
      en = 1'b1;
      sb.push_back('{0, 0, 0, 0, c0 + 101});
      sb.push_back('{1, 0, 1, 0, c0 + 201});
      sb.push_back('{0, 0, 0, 0, c0 + 301});
      for (int i = 0; i <= 402; i++) begin
         if (i > 0) tick();
         enc_in = (i >= 99) && (i <= 398);
         if (i == 301) en = 1'b0;
      end
      tick();

      // Test 6: async reset mid-window at timer 40, then restart under en.
      c0 = cyc;
      en = 1'b1;
      sb.push_back('{6, 0, 6, 0, c0 + 101});
      for (int i = 0; i <= 246; i++) begin
         if (i > 0) tick();
         enc_in = ((i < 12) && ((i % 2) == 0)) || ((i >= 101) && (i < 113) && ((i % 2) == 1));
         if (i == 141) begin
            #2 rst = 1'b1;
            #1;
            cmp("t6_speed16", int'(speed16), 0);
            cmp("t6_valid16", int'(valid16), 0);
            cmp("t6_ovf16", int'(ovf16), 0);
            cmp("t6_busy16", int'(busy16), 0);
            cmp("t6_speed4", int'(speed4), 0);
         end
         if (i == 142) cmp("t6_busy_in_rst", int'(busy16), 0);
         if (i == 143) begin
            #2 rst = 1'b0;
            sb.push_back('{0, 0, 0, 0, c0 + 244});
         end
         if (i == 244) en = 1'b0;
         if (i == 245) cmp("t6_busy_drop", int'(busy16), 0);
      end

      for (int i = 0; i < 5; i++) tick();
      cmp("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
